pgm_loader: RTL
===============

Name: pgm_loader

Overview:
- Writer side of the program-memory fetch path. The CPU only reads program memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake. The stream is a 2-byte header (start address, length) followed by payload bytes.
- Writes the payload bytes sequentially into the program-memory write port.
- Holds the CPU in reset for the whole load, then releases it so execution begins from the freshly loaded image.

Parameters:
- HOLD_CYCLES, 4: cycles cpu_hold stays asserted after the last write completes (1..255).

Ports:
- clk  input  1  system clock; every register updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data holds a valid byte.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- load_req  input  1  single-cycle pulse; starts a new load from RUN.
- pm_we  output  1  program-memory write enable, one cycle per byte.
- pm_addr  output  8  program-memory write address.
- pm_wdata  output  8  program-memory write data.
- cpu_hold  output  1  active-high reset to the CPU.
- done  output  1  high while in RUN.
- error  output  1  sticky checksum error (only meaningful with the optional feature).

Behaviour:
- Reset (reset=0 at a clk edge) gives: state=HDR_ADDR, in_ready=0, pm_we=0, pm_addr=8'h00, pm_wdata=8'h00, cpu_hold=1, done=0, error=0, internal counters=0.
- A transfer happens on any edge where in_valid && in_ready.
- in_ready is registered. It is 1 in HDR_ADDR, HDR_LEN, DATA and CHK, except on the first cycle after reset deasserts, when it is still 0. It is 0 in RELEASE and RUN.
- in_ready drops in the same edge that moves the state machine into a non-accepting state, so no byte is ever accepted beyond the expected count.
- HDR_ADDR: a transfer latches the address pointer = in_data. Next state HDR_LEN.
- HDR_LEN: a transfer latches remaining = in_data, with 8'h00 meaning 256 bytes. Next state DATA.
- DATA: each transfer drives registered outputs on the next edge: pm_we=1, pm_addr=pointer, pm_wdata=in_data.
  - The pointer then increments and wraps 8'hFF to 8'h00. remaining decrements.
  - Write latency is one cycle after acceptance. pm_we is 0 on every cycle with no transfer.
  - After the last byte, the next state is CHK if the optional feature is compiled in, otherwise RELEASE.
- RELEASE: cpu_hold stays 1 for HOLD_CYCLES cycles, counted from the cycle after the final pm_we pulse. Then cpu_hold=0, done=1, next state RUN.
- RUN: a load_req=1 edge gives, on that same edge: cpu_hold=1, done=0, error=0, state=HDR_ADDR, in_ready=1.
- load_req is ignored in every state except RUN. A load therefore cannot be restarted mid-transfer; only reset aborts it.
- Reset mid-load: the partial image stays in memory, state returns to HDR_ADDR, and cpu_hold stays 1.
- in_valid held with no transfer (ready=0) has no effect, and in_data is not sampled.
- Stalls: any number of in_valid=0 gaps are legal between bytes in every accepting state.

Optional Feature:
- Macro: PGM_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator covers every payload byte; it is cleared in HDR_ADDR.
  - In CHK, one extra stream byte is accepted and compared with the accumulator.
  - On a match: go to RELEASE.
  - On a mismatch: error=1, cpu_hold stays 1, done stays 0, state=RUN. load_req is honoured to retry.
- Undefined:
  - No CHK state and no accumulator; error is tied 0.
  - The stream is header plus payload only.

Test Plan:
- Stream 00,05,80,AA,20,90,02 with continuous valid → pm_we pulses at addresses 00..04 with data 80,AA,20,90,02; cpu_hold falls exactly 4 cycles after the last pm_we; done=1.
- Start address FE, length 03, data 11,22,33 → writes FE=11, FF=22, 00=33 (wrap); in_ready=0 after the 3rd payload byte.
- Length 00 → exactly 256 pm_we pulses; a 257th offered byte is not accepted (in_ready=0).
- Random in_valid gaps plus reset=0 after 2 payload bytes → state HDR_ADDR, cpu_hold=1, pm_we=0; a subsequent full load succeeds.
- In RUN, pulse load_req → cpu_hold=1 and done=0 on the same edge; reload 10,01,55 → single write 10=55, release again.
- With PGM_LOADER_CHECKSUM_EN: payload 80,AA with checksum 2A → release. With checksum 00 → error=1, cpu_hold stays 1, then load_req retry succeeds and error clears.

Source files
------------

// File: rtl/pgm_loader.sv
// pgm_loader: fills program memory from a valid/ready byte stream.
// Stream layout: start address, length (0 means 256), payload bytes.
// The CPU is held in reset for the whole load and released HOLD_CYCLES
// cycles after the loader leaves the data phase.
// Optional build macro PGM_LOADER_CHECKSUM_EN: a trailing XOR checksum byte
// follows the payload; a mismatch sets a sticky error and keeps the CPU held.
module pgm_loader #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       load_req,
   output logic       pm_we,
   output logic [7:0] pm_addr,
   output logic [7:0] pm_wdata,
   output logic       cpu_hold,
   output logic       done,
   output logic       error
);

   typedef enum logic [2:0] {
      HDR_ADDR,
      HDR_LEN,
      DATA,
`ifdef PGM_LOADER_CHECKSUM_EN
      CHK,
`endif
      RELEASE,
      RUN
   } state_t;

   state_t     state;
   logic [7:0] pointer;
   logic [8:0] remaining;   // 9 bits so a length byte of 0 can hold 256
   logic [7:0] hold_cnt;
   logic       xfer;

`ifdef PGM_LOADER_CHECKSUM_EN
   logic [7:0] csum;
   logic       err_q;
   assign error = err_q;
`else
   assign error = 1'b0;
`endif

   assign xfer = in_valid && in_ready;

   // Stream parser, memory write port and CPU hold sequencing.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge only, so it never appears in
      // the sensitivity list; every register below uses <= to avoid ordering races.
      if (!reset) begin
         state     <= HDR_ADDR;
         in_ready  <= 1'b0;
         pm_we     <= 1'b0;
         pm_addr   <= 8'h00;
         pm_wdata  <= 8'h00;
         cpu_hold  <= 1'b1;
         done      <= 1'b0;
         pointer   <= 8'h00;
         remaining <= 9'd0;
         hold_cnt  <= 8'h00;
`ifdef PGM_LOADER_CHECKSUM_EN
         csum      <= 8'h00;
         err_q     <= 1'b0;
`endif
      end else begin
         // Write strobe is a single-cycle pulse; only a DATA transfer raises it.
         pm_we <= 1'b0;
         case (state)
            HDR_ADDR: begin
               // NOTE: in_ready is registered, so it rises one edge after reset
               // releases and must be cleared on the edge that leaves an accepting state.
               in_ready <= 1'b1;
`ifdef PGM_LOADER_CHECKSUM_EN
               csum <= 8'h00;
`endif
               if (xfer) begin
                  pointer <= in_data;
                  state   <= HDR_LEN;
               end
            end
            HDR_LEN: begin
               if (xfer) begin
                  remaining <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                  state     <= DATA;
               end
            end
            DATA: begin
               if (xfer) begin
                  pm_we     <= 1'b1;
                  pm_addr   <= pointer;
                  pm_wdata  <= in_data;
                  pointer   <= pointer + 8'd1;
                  remaining <= remaining - 9'd1;
`ifdef PGM_LOADER_CHECKSUM_EN
                  csum <= csum ^ in_data;
                  if (remaining == 9'd1) begin
                     state <= CHK;
                  end
`else
                  if (remaining == 9'd1) begin
                     state    <= RELEASE;
                     in_ready <= 1'b0;
                     hold_cnt <= 8'h00;
                  end
`endif
               end
            end
`ifdef PGM_LOADER_CHECKSUM_EN
            CHK: begin
               if (xfer) begin
                  in_ready <= 1'b0;
                  hold_cnt <= 8'h00;
                  if (in_data == csum) begin
                     state <= RELEASE;
                  end else begin
                     err_q <= 1'b1;
                     state <= RUN;
                  end
               end
            end
`endif
            RELEASE: begin
               if (hold_cnt == 8'(HOLD_CYCLES)) begin
                  cpu_hold <= 1'b0;
                  done     <= 1'b1;
                  state    <= RUN;
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            RUN: begin
               if (load_req) begin
                  cpu_hold <= 1'b1;
                  done     <= 1'b0;
                  in_ready <= 1'b1;
                  state    <= HDR_ADDR;
`ifdef PGM_LOADER_CHECKSUM_EN
                  err_q    <= 1'b0;
`endif
               end
            end
            default: begin
               state    <= HDR_ADDR;
               in_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
